// File: rtl/gascore_arb_pkg.sv
// Shared types and helpers for the GAScore ingress packet arbiter.
// Build option AM_ARB_PKT_COUNT_EN enables per-source packet counters.
package gascore_arb_pkg;

  localparam int COUNT_WIDTH = 16;
  localparam int MAX_PORTS   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ERROR = 2'd3
  } arb_state_e;

  // First set request at or after ptr, wrapping modulo n.
  function automatic logic [3:0] rr_pick(
    input logic [MAX_PORTS-1:0] req,
    input logic [3:0]           ptr,
    input int                   n
  );
    int k;
    rr_pick = ptr;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (i < n) begin
        k = (int'(ptr) + i) % n;
        if (req[k]) rr_pick = 4'(k);
      end
    end
  endfunction

endpackage

// File: rtl/am_packet_arbiter_rr_select.sv
// Round-robin priority select: rotate by ptr, find first, unrotate.
// Part of am_packet_arbiter (option AM_ARB_PKT_COUNT_EN lives in the top).
module rr_priority_select #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] sel,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             ff;
  int             sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[int'(ptr) +: N];
    ff  = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) ff = i;
    end
    sum = int'(ptr) + ff;
    if (sum >= N) sum = sum - N;
    sel = SEL_W'(sum);
    any = |req;
  end

endmodule

// File: rtl/am_packet_arbiter.sv
// Packet-level round-robin AXIS arbiter feeding the GAScore ID-tagging stage.
// Define AM_ARB_PKT_COUNT_EN to add pkt_count / clear_counts.
module am_packet_arbiter
  import gascore_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_WIDTH = 64,
  parameter int TDEST_WIDTH = 16,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int SEL_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0] in_TDATA,
  input  logic [NUM_PORTS-1:0]             in_TVALID,
  output logic [NUM_PORTS-1:0]             in_TREADY,
  input  logic [NUM_PORTS*TDEST_WIDTH-1:0] in_TDEST,
  input  logic [NUM_PORTS-1:0]             in_TLAST,
  input  logic [NUM_PORTS*TKEEP_WIDTH-1:0] in_TKEEP,
  output logic [TDATA_WIDTH-1:0]           out_TDATA,
  output logic                             out_TVALID,
  input  logic                             out_TREADY,
  output logic [TDEST_WIDTH-1:0]           out_TDEST,
  output logic                             out_TLAST,
  output logic [TKEEP_WIDTH-1:0]           out_TKEEP,
  output logic [SEL_WIDTH-1:0]             grant_idx,
  output logic                             grant_active
`ifdef AM_ARB_PKT_COUNT_EN
  ,
  output logic [NUM_PORTS*COUNT_WIDTH-1:0] pkt_count,
  input  logic                             clear_counts
`endif
);

  arb_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_WIDTH-1:0] grant_q, grant_d;
  logic [SEL_WIDTH-1:0] pick;
  logic                 any_req;
  logic                 busy;
  logic                 last_hs;

  rr_priority_select #(
    .N     (NUM_PORTS),
    .SEL_W (SEL_WIDTH)
  ) u_sel (
    .req (in_TVALID),
    .ptr (rr_ptr_q),
    .sel (pick),
    .any (any_req)
  );

  assign busy         = (state_q == BUSY);
  assign grant_idx    = grant_q;
  assign grant_active = busy;

  always_comb begin
    out_TDATA  = in_TDATA[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
    out_TDEST  = in_TDEST[int'(grant_q)*TDEST_WIDTH +: TDEST_WIDTH];
    out_TKEEP  = in_TKEEP[int'(grant_q)*TKEEP_WIDTH +: TKEEP_WIDTH];
    out_TLAST  = in_TLAST[grant_q];
    out_TVALID = busy & in_TVALID[grant_q];
    in_TREADY  = '0;
    if (busy) in_TREADY[grant_q] = out_TREADY;
    last_hs    = out_TVALID & out_TREADY & out_TLAST;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_hs) begin
          if (grant_q == SEL_WIDTH'(NUM_PORTS - 1)) rr_ptr_d = '0;
          else rr_ptr_d = grant_q + SEL_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

`ifdef AM_ARB_PKT_COUNT_EN
  logic [COUNT_WIDTH-1:0] cnt_q [NUM_PORTS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_PORTS];

  // Clear wins over a same-cycle TLAST increment.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_counts) cnt_d[i] = '0;
      else if (last_hs && grant_q == SEL_WIDTH'(i))
        cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
      pkt_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[i];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`endif

endmodule
